// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - framed byte stream to 24-bit program ROM word writer with CPU hold
// Optional echo of received bytes on tx_data/tx_valid when LOADER_ECHO_EN is defined.
module rom_loader #(
    parameter int          ROM_DEPTH    = 256,
    parameter int          ADDR_W       = 8,
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter int          IDLE_TIMEOUT = 270000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rom_w_enable,
    output logic [ADDR_W-1:0] rom_w_addr,
    output logic [23:0]       rom_w_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [7:0]        tx_data,
    output logic              tx_valid
);

    localparam int TMO_W = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_B0, S_B1, S_B2, S_CHECK
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        sum_q, sum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [8:0]        n_q, n_d;
    logic [8:0]        words_q, words_d;
    logic [7:0]        op_q, op_d;
    logic [7:0]        arga_q, arga_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [23:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            sum_q   <= '0;
            tmo_q   <= '0;
            n_q     <= '0;
            words_q <= '0;
            op_q    <= '0;
            arga_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            tmo_q   <= tmo_d;
            n_q     <= n_d;
            words_q <= words_d;
            op_q    <= op_d;
            arga_q  <= arga_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        tmo_d   = tmo_q;
        n_d     = n_q;
        words_d = words_q;
        op_d    = op_q;
        arga_d  = arga_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = err_q;

        // A byte arriving in the expiry cycle wins over the timeout.
        if (state_q != S_IDLE) begin
            if (rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_W'(IDLE_TIMEOUT - 1)) begin
                tmo_d   = '0;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == HEADER) begin
                        hold_d  = 1'b1;
                        err_d   = 1'b0;
                        addr_d  = '0;
                        sum_d   = '0;
                        words_d = '0;
                        tmo_d   = '0;
                        state_d = S_COUNT;
                    end
                end
                S_COUNT: begin
                    n_d     = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    sum_d   = rx_data;
                    words_d = '0;
                    state_d = S_B0;
                end
                S_B0: begin
                    op_d    = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = S_B1;
                end
                S_B1: begin
                    arga_d  = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = S_B2;
                end
                S_B2: begin
                    sum_d   = sum_q + rx_data;
                    wen_d   = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = {op_q, arga_q, rx_data};
                    addr_d  = (addr_q == ADDR_W'(ROM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
                    words_d = words_q + 9'd1;
                    state_d = (words_q + 9'd1 == n_q) ? S_CHECK : S_B0;
                end
                S_CHECK: begin
                    if (rx_data == sum_q) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign rom_w_enable = wen_q;
    assign rom_w_addr   = waddr_q;
    assign rom_w_data   = wdata_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_error   = err_q;

`ifdef LOADER_ECHO_EN
    logic [7:0] tx_data_q;
    logic       tx_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            tx_valid_q <= rx_valid;
            if (rx_valid) begin
                tx_data_q <= rx_data;
            end
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
`else
    assign tx_data  = 8'd0;
    assign tx_valid = 1'b0;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - scoreboard bench for rom_loader
// Expected ROM writes (and echoes under LOADER_ECHO_EN) are queued at stimulus time and popped by a monitor.
module tb_rom_loader;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rom_w_enable;
    logic [7:0]  rom_w_addr;
    logic [23:0] rom_w_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [7:0]  tx_data;
    logic        tx_valid;

    rom_loader #(
        .ROM_DEPTH   (256),
        .ADDR_W      (8),
        .HEADER      (8'hA5),
        .IDLE_TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rom_w_enable(rom_w_enable),
        .rom_w_addr  (rom_w_addr),
        .rom_w_data  (rom_w_data),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_error  (load_error),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    logic [31:0] wr_q[$];
    logic [7:0]  echo_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rom_w_enable === 1'b1) begin
            wr_cnt++;
            if (wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h required=none", {rom_w_addr, rom_w_data});
            end else begin
                chk("rom_write", {rom_w_addr, rom_w_data}, wr_q.pop_front());
            end
        end
        if (load_done === 1'b1) done_cnt++;
`ifdef LOADER_ECHO_EN
        if (tx_valid === 1'b1) begin
            if (echo_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_echo actual=%0h required=none", tx_data);
            end else begin
                chk("echo", {24'd0, tx_data}, {24'd0, echo_q.pop_front()});
            end
        end
`endif
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
`ifdef LOADER_ECHO_EN
        echo_q.push_back(b);
`endif
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic exp_write(input logic [7:0] a, input logic [23:0] d);
        wr_q.push_back({a, d});
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic frame_one();
        exp_write(8'h00, 24'h100205);
        send_byte(8'hA5); send_byte(8'h01);
        send_byte(8'h10); send_byte(8'h02); send_byte(8'h05);
        send_byte(8'h18);
    endtask

    task automatic frame_two(input logic [7:0] c);
        exp_write(8'h00, 24'h110102);
        exp_write(8'h01, 24'h200304);
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h03); send_byte(8'h04);
        send_byte(c);
    endtask

    int         w0, d0;
    logic [7:0] s, op, aa, bb;

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {rom_w_enable, rom_w_addr, rom_w_data, cpu_hold, load_done, load_error, tx_data, tx_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single word
        w0 = wr_cnt; d0 = done_cnt;
        frame_one();
        settle(3);
        chk("t1_writes", wr_cnt - w0, 1);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_hold", cpu_hold, 0);
        chk("t1_err", load_error, 0);

        // two words, good checksum
        w0 = wr_cnt; d0 = done_cnt;
        frame_two(8'h3D);
        settle(3);
        chk("t2_writes", wr_cnt - w0, 2);
        chk("t2_done", done_cnt - d0, 1);
        chk("t2_hold", cpu_hold, 0);

        // bad checksum, then recovery
        w0 = wr_cnt; d0 = done_cnt;
        frame_two(8'h3E);
        settle(3);
        chk("t3_writes", wr_cnt - w0, 2);
        chk("t3_err", load_error, 1);
        chk("t3_hold", cpu_hold, 1);
        chk("t3_done", done_cnt - d0, 0);
        d0 = done_cnt;
        frame_one();
        settle(3);
        chk("t3_recover_err", load_error, 0);
        chk("t3_recover_hold", cpu_hold, 0);
        chk("t3_recover_done", done_cnt - d0, 1);

        // timeout boundary
        w0 = wr_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
        repeat (TMO - 1) @(posedge clk);
        @(negedge clk);
        chk("t4_err_before_limit", load_error, 0);
        @(posedge clk);
        @(negedge clk);
        chk("t4_err_at_limit", load_error, 1);
        chk("t4_hold", cpu_hold, 1);
        #1;
        send_byte(8'h02);
        settle(3);
        chk("t4_writes", wr_cnt - w0, 0);
        chk("t4_err_kept", load_error, 1);

        // full 256-word frame with leading junk
        w0 = wr_cnt; d0 = done_cnt;
        send_byte(8'h33); send_byte(8'h7E);
        send_byte(8'hA5); send_byte(8'h00);
        s = 8'h00;
        for (int i = 0; i < 256; i++) begin
            op = 8'(i);
            aa = 8'(i) ^ 8'h5A;
            bb = ~8'(i);
            exp_write(8'(i), {op, aa, bb});
            send_byte(op); send_byte(aa); send_byte(bb);
            s = s + op + aa + bb;
        end
        send_byte(s);
        settle(3);
        chk("t5_writes", wr_cnt - w0, 256);
        chk("t5_done", done_cnt - d0, 1);
        chk("t5_err", load_error, 0);
        chk("t5_hold", cpu_hold, 0);

        // reset mid-frame
        w0 = wr_cnt; d0 = done_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h02);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        settle(3);
        chk("t6_hold", cpu_hold, 0);
        chk("t6_writes", wr_cnt - w0, 0);
        frame_one();
        settle(3);
        chk("t6_after_done", done_cnt - d0, 1);
        chk("t6_after_hold", cpu_hold, 0);

`ifndef LOADER_ECHO_EN
        chk("echo_disabled", {tx_data, tx_valid}, 9'd0);
`endif
        chk("write_queue_drained", wr_q.size(), 0);
        chk("echo_queue_drained", echo_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
